// File: rtl/siso_shift_ctrl.sv
`default_nettype none
// =============================================================================
// siso_shift_ctrl : serializes valid/ready words LSB-first into a SISO shift
//                   register with frame markers and a programmable idle gap.
// Optional feature macro : SISO_SHIFT_CTRL_PARITY_EN (adds one even-parity bit)
// Revision : 1.0
// =============================================================================

module siso_shift_ctrl #(
  parameter int DATA_WIDTH = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  abort,
  output logic                  sr_din,
  output logic                  sr_shift_en,
  output logic                  frame_start,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int               C_CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [C_CNT_W-1:0] C_LAST_BIT = C_CNT_W'(DATA_WIDTH - 1);
  localparam logic [3:0]       C_GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
`ifdef SISO_SHIFT_CTRL_PARITY_EN
    ST_PARITY = 2'd2,
`endif
    ST_GAP    = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_n;
  state_t               w_after_frame;
  logic [DATA_WIDTH-1:0] r_hold;
  logic [DATA_WIDTH-1:0] w_hold_n;
  logic [C_CNT_W-1:0]   r_cnt;
  logic [C_CNT_W-1:0]   w_cnt_n;
  logic [3:0]           r_gap_cnt;
  logic [3:0]           w_gap_n;
`ifdef SISO_SHIFT_CTRL_PARITY_EN
  logic                 r_parity;
  logic                 w_parity_n;
`endif

  // With no gap configured the frame ends straight back in IDLE.
  generate
    if (GAP_CYCLES == 0) begin : g_no_gap
      assign w_after_frame = ST_IDLE;
    end else begin : g_gap
      assign w_after_frame = ST_GAP;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_hold    <= '0;
      r_cnt     <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_n;
      r_hold    <= w_hold_n;
      r_cnt     <= w_cnt_n;
      r_gap_cnt <= w_gap_n;
    end
  end

`ifdef SISO_SHIFT_CTRL_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_parity <= 1'b0;
    end else begin
      r_parity <= w_parity_n;
    end
  end
`endif

  always_comb begin
    w_state_n   = r_state;
    w_hold_n    = r_hold;
    w_cnt_n     = r_cnt;
    w_gap_n     = r_gap_cnt;
    sr_din      = 1'b0;
    sr_shift_en = 1'b0;
    frame_start = 1'b0;
    frame_done  = 1'b0;
`ifdef SISO_SHIFT_CTRL_PARITY_EN
    w_parity_n  = r_parity;
`endif
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_hold_n  = in_data;
          w_cnt_n   = '0;
          w_state_n = ST_SHIFT;
`ifdef SISO_SHIFT_CTRL_PARITY_EN
          w_parity_n = ^in_data;
`endif
        end
      end

      ST_SHIFT: begin
        sr_shift_en = 1'b1;
        sr_din      = r_hold[0];
        frame_start = (r_cnt == '0);
        w_hold_n    = r_hold >> 1;
        w_cnt_n     = r_cnt + 1'b1;
        if (r_cnt == C_LAST_BIT) begin
          w_cnt_n = '0;
          w_gap_n = '0;
`ifdef SISO_SHIFT_CTRL_PARITY_EN
          w_state_n = ST_PARITY;
`else
          frame_done = 1'b1;
          w_state_n  = w_after_frame;
`endif
        end
        // Bits already driven stay in the shift register; only the source is dropped.
        if (abort) begin
          w_state_n = ST_IDLE;
          w_hold_n  = '0;
          w_cnt_n   = '0;
        end
      end

`ifdef SISO_SHIFT_CTRL_PARITY_EN
      ST_PARITY: begin
        sr_shift_en = 1'b1;
        sr_din      = r_parity;
        frame_done  = 1'b1;
        w_gap_n     = '0;
        w_state_n   = w_after_frame;
        if (abort) begin
          w_state_n = ST_IDLE;
          w_hold_n  = '0;
        end
      end
`endif

      ST_GAP: begin
        w_gap_n = r_gap_cnt + 1'b1;
        if (r_gap_cnt == C_GAP_LAST) begin
          w_state_n = ST_IDLE;
          w_gap_n   = '0;
        end
        if (abort) begin
          w_state_n = ST_IDLE;
          w_hold_n  = '0;
          w_gap_n   = '0;
        end
      end

      default: begin
        w_state_n = ST_IDLE;
      end
    endcase
  end

  // Reset forces IDLE, so gating with rst keeps in_ready low while reset is held.
  assign in_ready = (r_state == ST_IDLE) && !rst;
  assign busy     = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_siso_shift_ctrl.sv
`default_nettype none
// Bench for siso_shift_ctrl: randomized words against a frame-level model,
// plus a second instance with GAP_CYCLES=0.
`timescale 1ns/1ps

module tb_siso_shift_ctrl;

  localparam int DW  = 4;
  localparam int GAP = 1;
`ifdef SISO_SHIFT_CTRL_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int L = DW + P;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          abort = 1'b0;
  logic          in_ready, sr_din, sr_shift_en, frame_start, frame_done, busy;

  logic          v0 = 1'b0;
  logic [DW-1:0] d0 = '0;
  logic          ab0 = 1'b0;
  logic          in_ready0, sr_din0, sr_shift_en0, frame_start0, frame_done0, busy0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  siso_shift_ctrl #(.DATA_WIDTH(DW), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .abort(abort), .sr_din(sr_din), .sr_shift_en(sr_shift_en),
    .frame_start(frame_start), .frame_done(frame_done), .busy(busy)
  );

  siso_shift_ctrl #(.DATA_WIDTH(DW), .GAP_CYCLES(0)) dut_gap0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_data(d0), .in_ready(in_ready0),
    .abort(ab0), .sr_din(sr_din0), .sr_shift_en(sr_shift_en0),
    .frame_start(frame_start0), .frame_done(frame_done0), .busy(busy0)
  );

  // Bit k of a frame: data bits LSB first, then the even-parity bit.
  function automatic logic exp_bit(input logic [DW-1:0] w, input int k);
    if (k < DW) return w[k];
    return ^w;
  endfunction

  task automatic test_reset();
    logic [5:0] obs;
    #1;
    obs = {in_ready, busy, sr_shift_en, sr_din, frame_start, frame_done};
    tests++; if (obs !== 6'b000000) begin fails++; $display("FAIL reset_outputs got %b want 000000", obs); end
    obs = {in_ready0, busy0, sr_shift_en0, sr_din0, frame_start0, frame_done0};
    tests++; if (obs !== 6'b000000) begin fails++; $display("FAIL reset_outputs_gap0 got %b want 000000", obs); end
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    obs = {in_ready, busy, sr_shift_en, sr_din, frame_start, frame_done};
    tests++; if (obs !== 6'b100000) begin fails++; $display("FAIL reset_release got %b want 100000", obs); end
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [DW-1:0] w;
    logic [5:0]    obs, exp;
    for (int n = 0; n < 12; n++) begin
      w = (n == 0) ? 4'b1011 : DW'($urandom);
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL single_ready_idle got %b want 1", in_ready); end
      in_valid = 1'b1; in_data = w;
      @(negedge clk);
      in_valid = 1'b0; in_data = '0;
      for (int j = 1; j <= L + GAP; j++) begin
        if (j <= L) exp = {1'b0, 1'b1, 1'b1, exp_bit(w, j - 1), (j == 1), (j == L)};
        else        exp = 6'b010000;
        obs = {in_ready, busy, sr_shift_en, sr_din, frame_start, frame_done};
        tests++; if (obs !== exp) begin fails++; $display("FAIL single w=%h cyc=%0d got %b want %b", w, j, obs, exp); end
        @(negedge clk);
      end
      obs = {in_ready, busy, sr_shift_en, sr_din, frame_start, frame_done};
      tests++; if (obs !== 6'b100000) begin fails++; $display("FAIL single_back_idle w=%h got %b want 100000", w, obs); end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] words[$];
    logic          exp_bits[$];
    logic          got_bits[$];
    int            acc[$];
    int            idx, nstart, ndone, ncyc;
    words.push_back(4'h3); words.push_back(4'hC);
    for (int i = 0; i < 4; i++) words.push_back(DW'($urandom));
    foreach (words[i]) for (int k = 0; k < L; k++) exp_bits.push_back(exp_bit(words[i], k));
    idx = 0; nstart = 0; ndone = 0;
    ncyc = words.size() * (1 + L + GAP) + 2;
    in_valid = 1'b1; in_data = words[0];
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      if (sr_shift_en) got_bits.push_back(sr_din);
      nstart += int'(frame_start); ndone += int'(frame_done);
      tests++; if (in_ready !== !busy) begin fails++; $display("FAIL b2b_ready_outside_idle cyc=%0d got %b want %b", cyc, in_ready, !busy); end
      if (in_ready && in_valid) begin acc.push_back(cyc); idx++; end
      @(negedge clk);
      if (idx < words.size()) in_data = words[idx];
      else begin in_valid = 1'b0; in_data = '0; end
    end
    tests++; if (idx != words.size()) begin fails++; $display("FAIL b2b_accepted got %0d want %0d", idx, words.size()); end
    for (int i = 1; i < acc.size(); i++) begin
      tests++; if (acc[i] - acc[i-1] != 1 + L + GAP) begin fails++; $display("FAIL b2b_period i=%0d got %0d want %0d", i, acc[i] - acc[i-1], 1 + L + GAP); end
    end
    tests++;
    if (got_bits.size() != exp_bits.size()) begin
      fails++; $display("FAIL b2b_bitcount got %0d want %0d", got_bits.size(), exp_bits.size());
    end else begin
      for (int i = 0; i < exp_bits.size(); i++) begin
        tests++; if (got_bits[i] !== exp_bits[i]) begin fails++; $display("FAIL b2b_bit i=%0d got %b want %b", i, got_bits[i], exp_bits[i]); end
      end
    end
    tests++; if (nstart != words.size() || ndone != words.size()) begin
      fails++; $display("FAIL b2b_markers got start=%0d done=%0d want %0d", nstart, ndone, words.size());
    end
  endtask

  task automatic test_abort();
    logic [DW-1:0] w;
    logic [5:0]    obs, exp;
    int            k, pulses, dones;
    for (int n = 0; n < 8; n++) begin
      w = (n == 0) ? 4'hA : DW'($urandom);
      k = (n == 0) ? 2 : (n == 7) ? L : int'($urandom_range(1, L));
      in_valid = 1'b1; in_data = w;
      @(negedge clk);
      in_valid = 1'b0; in_data = '0;
      pulses = 0; dones = 0;
      for (int j = 1; j <= k; j++) begin
        pulses += int'(sr_shift_en); dones += int'(frame_done);
        if (j == k) abort = 1'b1;
        @(negedge clk);
      end
      abort = 1'b0;
      obs = {in_ready, busy, sr_shift_en, sr_din, frame_start, frame_done};
      tests++; if (obs !== 6'b100000) begin fails++; $display("FAIL abort_to_idle w=%h k=%0d got %b want 100000", w, k, obs); end
      tests++; if (pulses != k || dones != int'(k == L)) begin
        fails++; $display("FAIL abort_pulses k=%0d got en=%0d done=%0d want en=%0d done=%0d", k, pulses, dones, k, int'(k == L));
      end
      @(negedge clk);
      tests++; if (sr_shift_en !== 1'b0) begin fails++; $display("FAIL abort_quiet got %b want 0", sr_shift_en); end
    end
    // abort in IDLE is ignored and the handshake completes
    w = DW'($urandom);
    abort = 1'b1; in_valid = 1'b1; in_data = w;
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0; in_data = '0;
    for (int j = 1; j <= L + GAP; j++) begin
      if (j <= L) exp = {1'b0, 1'b1, 1'b1, exp_bit(w, j - 1), (j == 1), (j == L)};
      else        exp = 6'b010000;
      obs = {in_ready, busy, sr_shift_en, sr_din, frame_start, frame_done};
      tests++; if (obs !== exp) begin fails++; $display("FAIL abort_idle_frame cyc=%0d got %b want %b", j, obs, exp); end
      @(negedge clk);
    end
  endtask

  task automatic test_gap0();
    logic [DW-1:0] words[$];
    logic          exp_bits[$];
    logic          got_bits[$];
    int            acc[$];
    int            idx, ncyc;
    logic          prev_done;
    words.push_back(4'h5);
    for (int i = 0; i < 3; i++) words.push_back(DW'($urandom));
    foreach (words[i]) for (int k = 0; k < L; k++) exp_bits.push_back(exp_bit(words[i], k));
    idx = 0; prev_done = 1'b0;
    ncyc = words.size() * (1 + L) + 2;
    v0 = 1'b1; d0 = words[0];
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      if (prev_done) begin
        tests++; if (in_ready0 !== 1'b1) begin fails++; $display("FAIL gap0_ready_after_done cyc=%0d got %b want 1", cyc, in_ready0); end
      end
      prev_done = frame_done0;
      if (sr_shift_en0) got_bits.push_back(sr_din0);
      if (in_ready0 && v0) begin acc.push_back(cyc); idx++; end
      @(negedge clk);
      if (idx < words.size()) d0 = words[idx];
      else begin v0 = 1'b0; d0 = '0; end
    end
    tests++; if (idx != words.size()) begin fails++; $display("FAIL gap0_accepted got %0d want %0d", idx, words.size()); end
    for (int i = 1; i < acc.size(); i++) begin
      tests++; if (acc[i] - acc[i-1] != 1 + L) begin fails++; $display("FAIL gap0_period i=%0d got %0d want %0d", i, acc[i] - acc[i-1], 1 + L); end
    end
    tests++;
    if (got_bits.size() != exp_bits.size()) begin
      fails++; $display("FAIL gap0_bitcount got %0d want %0d", got_bits.size(), exp_bits.size());
    end else begin
      for (int i = 0; i < exp_bits.size(); i++) begin
        tests++; if (got_bits[i] !== exp_bits[i]) begin fails++; $display("FAIL gap0_bit i=%0d got %b want %b", i, got_bits[i], exp_bits[i]); end
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [5:0] obs;
    in_valid = 1'b1; in_data = 4'hF;
    @(negedge clk);
    in_valid = 1'b0; in_data = '0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    obs = {in_ready, busy, sr_shift_en, sr_din, frame_start, frame_done};
    tests++; if (obs !== 6'b000000) begin fails++; $display("FAIL midframe_reset_async got %b want 000000", obs); end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    obs = {in_ready, busy, sr_shift_en, sr_din, frame_start, frame_done};
    tests++; if (obs !== 6'b100000) begin fails++; $display("FAIL midframe_release got %b want 100000", obs); end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      obs = {in_ready, busy, sr_shift_en, sr_din, frame_start, frame_done};
      tests++; if (obs !== 6'b100000) begin fails++; $display("FAIL midframe_discard cyc=%0d got %b want 100000", c, obs); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_abort();
    test_gap0();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
